// File: rtl/pong_engine.sv
// Two-player pong game core: paddles, ball kinematics, collisions, scoring and
// serve/point/game-over sequencing, advanced once per frame_tick.
module pong_engine #(
  parameter int unsigned SCR_W       = 640,
  parameter int unsigned SCR_H       = 480,
  parameter int unsigned PAD_W       = 8,
  parameter int unsigned PAD_H       = 50,
  parameter int unsigned BALL_S      = 8,
  parameter int unsigned P1_X        = 40,
  parameter int unsigned P2_X        = 600,
  parameter int unsigned P_SPD       = 16,
  parameter int unsigned BX_SPD      = 8,
  parameter int unsigned BY_SPD      = 8,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned BEEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  input  logic       p1_srv,
  input  logic       p2_srv,
  output logic [8:0] p1_y,
  output logic [8:0] p2_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] state,
  output logic       server,
  output logic       winner,
  output logic       beep_lo,
  output logic       beep_hi
);

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

  localparam int unsigned CW = $clog2(BEEP_FRAMES + 1);

  localparam logic [8:0] PAD_Y0 = 9'((SCR_H - PAD_H) / 2);
  localparam logic [9:0] PARK_L = 10'(P1_X + PAD_W);
  localparam logic [9:0] PARK_R = 10'(P2_X - BALL_S);
  localparam logic [8:0] PARK_Y = 9'((SCR_H - BALL_S) / 2);
  localparam logic [3:0] WIN    = 4'(WIN_SCORE);
  localparam logic [CW-1:0] BEEP_LD = CW'(BEEP_FRAMES);

  localparam logic signed [10:0] PAD_MAX_S = 11'(SCR_H - PAD_H);
  localparam logic signed [10:0] P_SPD_S   = 11'(P_SPD);
  localparam logic signed [10:0] PZERO_S   = '0;

  localparam logic signed [11:0] ZERO_S   = '0;
  localparam logic signed [11:0] BALL_S_S = 12'(BALL_S);
  localparam logic signed [11:0] PAD_H_S  = 12'(PAD_H);
  localparam logic signed [11:0] X_MAX_S  = 12'(SCR_W - BALL_S);
  localparam logic signed [11:0] Y_MAX_S  = 12'(SCR_H - BALL_S);
  localparam logic signed [11:0] P1_X_S   = 12'(P1_X);
  localparam logic signed [11:0] P1_R_S   = 12'(P1_X + PAD_W);
  localparam logic signed [11:0] P2_X_S   = 12'(P2_X);
  localparam logic signed [11:0] P2_R_S   = 12'(P2_X + PAD_W);
  localparam logic signed [11:0] BX_S     = 12'(BX_SPD);
  localparam logic signed [11:0] BY_S     = 12'(BY_SPD);

  state_t               st;
  logic                 p1_prev, p2_prev;
  logic                 p1_rise, p2_rise;
  logic signed [11:0]   vx, vy;
  logic [CW-1:0]        beep_cnt;
  logic [CW-1:0]        pt_cnt;

  logic [8:0]           p1_nxt, p2_nxt;
  logic signed [11:0]   nx_raw, ny_raw, ny_c, p1e, p2e;
  logic signed [11:0]   vx_n, vy_n;
  logic [9:0]           bx_n;
  logic [8:0]           by_n;
  logic                 ov1, ov2, wall, pad, miss_l, miss_r;

  function automatic logic [8:0] pad_next(input logic [8:0] y, input logic up, input logic dn);
    logic signed [10:0] t;
    t = $signed({2'b00, y});
    if (up && !dn)      t = t - P_SPD_S;
    else if (dn && !up) t = t + P_SPD_S;
    if (t < PZERO_S)        t = PZERO_S;
    else if (t > PAD_MAX_S) t = PAD_MAX_S;
    return t[8:0];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s < WIN) ? s + 4'd1 : s;
  endfunction

  assign p1_rise = p1_srv & ~p1_prev;
  assign p2_rise = p2_srv & ~p2_prev;
  assign state   = st;
  assign beep_lo = (beep_cnt != '0);

  // Wall clamp first, then paddle test against the clamped y and the paddles'
  // updated positions; miss is judged on the unclamped x and wins over a hit.
  always_comb begin
    p1_nxt = pad_next(p1_y, p1_up, p1_dn);
    p2_nxt = pad_next(p2_y, p2_up, p2_dn);
    nx_raw = $signed({2'b00, ball_x}) + vx;
    ny_raw = $signed({3'b000, ball_y}) + vy;
    ny_c   = ny_raw;
    vy_n   = vy;
    wall   = 1'b0;
    if (ny_raw <= ZERO_S) begin
      ny_c = ZERO_S;
      vy_n = BY_S;
      wall = 1'b1;
    end else if (ny_raw >= Y_MAX_S) begin
      ny_c = Y_MAX_S;
      vy_n = -BY_S;
      wall = 1'b1;
    end
    p1e  = $signed({3'b000, p1_nxt});
    p2e  = $signed({3'b000, p2_nxt});
    ov1  = (ny_c < p1e + PAD_H_S) && (ny_c + BALL_S_S > p1e);
    ov2  = (ny_c < p2e + PAD_H_S) && (ny_c + BALL_S_S > p2e);
    bx_n = nx_raw[9:0];
    vx_n = vx;
    pad  = 1'b0;
    if (vx < ZERO_S && nx_raw < P1_R_S && nx_raw + BALL_S_S > P1_X_S && ov1) begin
      bx_n = PARK_L;
      vx_n = BX_S;
      pad  = 1'b1;
    end else if (vx > ZERO_S && nx_raw < P2_R_S && nx_raw + BALL_S_S > P2_X_S && ov2) begin
      bx_n = PARK_R;
      vx_n = -BX_S;
      pad  = 1'b1;
    end
    miss_l = (nx_raw <= ZERO_S);
    miss_r = (nx_raw >= X_MAX_S);
    by_n   = ny_c[8:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= SERVE;
      p1_prev  <= 1'b0;
      p2_prev  <= 1'b0;
      p1_y     <= PAD_Y0;
      p2_y     <= PAD_Y0;
      ball_x   <= PARK_R;
      ball_y   <= PARK_Y;
      vx       <= '0;
      vy       <= '0;
      score1   <= '0;
      score2   <= '0;
      server   <= 1'b1;
      winner   <= 1'b0;
      beep_cnt <= '0;
      beep_hi  <= 1'b0;
      pt_cnt   <= '0;
    end else begin
      p1_prev <= p1_srv;
      p2_prev <= p2_srv;
      if (frame_tick) begin
        if (beep_cnt != '0) beep_cnt <= beep_cnt - 1'b1;
        if (st != OVER) begin
          p1_y <= p1_nxt;
          p2_y <= p2_nxt;
        end
      end
      case (st)
        SERVE: begin
          if (server ? p2_rise : p1_rise) begin
            st <= PLAY;
            vx <= server ? -BX_S : BX_S;
            vy <= BY_S;
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (miss_l || miss_r) begin
              st      <= POINT;
              vx      <= '0;
              vy      <= '0;
              beep_hi <= 1'b1;
              pt_cnt  <= BEEP_LD;
              if (miss_l) begin
                score2 <= sat_inc(score2);
                server <= 1'b0;
              end else begin
                score1 <= sat_inc(score1);
                server <= 1'b1;
              end
            end else begin
              ball_x <= bx_n;
              ball_y <= by_n;
              vx     <= vx_n;
              vy     <= vy_n;
              if (wall || pad) beep_cnt <= BEEP_LD;
            end
          end
        end
        POINT: begin
          if (frame_tick) begin
            if (pt_cnt <= 1) begin
              beep_hi <= 1'b0;
              pt_cnt  <= '0;
              ball_x  <= server ? PARK_R : PARK_L;
              ball_y  <= PARK_Y;
              // server was handed to the player who conceded, so the scorer is ~server
              if ((server ? score1 : score2) == WIN) begin
                st     <= OVER;
                winner <= ~server;
              end else begin
                st <= SERVE;
              end
            end else begin
              pt_cnt <= pt_cnt - 1'b1;
            end
          end
        end
        OVER: begin
          if (p1_rise || p2_rise) begin
            score1 <= '0;
            score2 <= '0;
            st     <= SERVE;
            server <= ~winner;
            ball_x <= winner ? PARK_L : PARK_R;
            ball_y <= PARK_Y;
          end
        end
        default: st <= SERVE;
      endcase
    end
  end

endmodule
